multidigit_display: RTL and testbench

Parametrised successor to the 4-digit decimal display driver. It converts a WIDTH-bit value to NUM_DIGITS seven-segment digits in decimal or hex mode, with optional signed display, leading-zero blanking and overflow indication. Decimal conversion uses an in-house serial divide-by-ten, so no vendor divider IP is needed. It refreshes continuously, and every update of the displayed digits is atomic.

---
 rtl/display_pkg.sv | 39 +++
 rtl/multidigit_display_if.sv | 24 ++
 rtl/div10_serial.sv | 60 ++++++
 rtl/multidigit_display.sv | 131 +++++++++++++
 tb/tb_multidigit_display.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM state encoding and the 16-entry glyph table
// for the multi-digit seven-segment display driver.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    S_LATCH,
    S_DIVIDE,
    S_STORE,
    S_COMMIT
  } state_e;

  // Active-low segments, bit0 = a .. bit6 = g.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/multidigit_display_if.sv
// Value/mode inputs and segment/status outputs of the display driver.
interface multidigit_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int WIDTH      = 32
);
  logic [WIDTH-1:0]        number_to_show;
  logic                    hex_mode;
  logic                    signed_mode;
  logic                    blank_leading;
  logic [7*NUM_DIGITS-1:0] HEX;
  logic                    busy;
  logic                    update_done;
  logic                    overflow;

  modport master (
    output number_to_show, hex_mode, signed_mode, blank_leading,
    input  HEX, busy, update_done, overflow
  );

  modport slave (
    input  number_to_show, hex_mode, signed_mode, blank_leading,
    output HEX, busy, update_done, overflow
  );
endinterface

// File: rtl/div10_serial.sv
// Restoring shift-subtract divide-by-ten: one quotient bit per cycle,
// results valid in the cycle after done_o.
module div10_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [3:0]       remainder_o
);
  localparam int CW = $clog2(WIDTH);

  logic             active_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [3:0]       rem_q;
  logic [4:0]       trial;
  logic             fits;
  logic [3:0]       rem_d;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    fits  = (trial >= 5'd10);
    rem_d = fits ? 4'(trial - 5'd10) : trial[3:0];
  end

  assign done_o      = active_q && (cnt_q == CW'(WIDTH - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done_o) active_q <= 1'b0;
    end
  end

  // NOTE: the datapath is deliberately not reset; start_i reloads it
  // before any result is consumed.
  always_ff @(posedge clk) begin
    if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
    end else if (active_q) begin
      quo_q <= {quo_q[WIDTH-2:0], fits};
      rem_q <= rem_d;
    end
  end
endmodule

// File: rtl/multidigit_display.sv
// Continuously converts a WIDTH-bit value into NUM_DIGITS seven-segment
// digits (decimal or hex), committing each complete frame atomically.
module multidigit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int WIDTH      = 32
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  multidigit_display_if.slave bus
);
  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                        state_q, state_d;
  logic [KW-1:0]                 digit_q;
  logic [WIDTH-1:0]              work_q;
  logic                          neg_q, hex_q, blank_q;
  logic [NUM_DIGITS-1:0][3:0]    buf_q;
  logic [7*NUM_DIGITS-1:0]       hex_out_q, seg_d;
  logic                          busy_q, done_q, ovf_q, ovf_d;

  logic                          in_neg;
  logic [WIDTH-1:0]              in_mag;
  logic                          div_start, div_done;
  logic [WIDTH-1:0]              div_dividend, div_quo;
  logic [3:0]                    div_rem;
  int                            msd;

  assign in_neg = bus.signed_mode && !bus.hex_mode && bus.number_to_show[WIDTH-1];
  assign in_mag = in_neg ? -bus.number_to_show : bus.number_to_show;
  assign div_dividend = (state_q == S_LATCH) ? in_mag : div_quo;

  div10_serial #(.WIDTH(WIDTH)) u_div (
    .clk        (CLOCK_50),
    .rst        (RST),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      S_LATCH: begin
        if (bus.hex_mode) begin
          state_d = S_STORE;
        end else begin
          state_d   = S_DIVIDE;
          div_start = 1'b1;
        end
      end
      S_DIVIDE: if (div_done) state_d = S_STORE;
      S_STORE: begin
        if (digit_q == KW'(NUM_DIGITS - 1)) begin
          state_d = S_COMMIT;
        end else if (!hex_q) begin
          state_d   = S_DIVIDE;
          div_start = 1'b1;
        end
      end
      S_COMMIT: state_d = S_LATCH;
      default:  state_d = S_LATCH;
    endcase
  end

  // Frame composition from the finished digit buffer.
  always_comb begin
    msd = 0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (buf_q[i] != 4'd0) msd = i;
    ovf_d = (work_q != '0) || (neg_q && buf_q[NUM_DIGITS-1] != 4'd0);
    seg_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ovf_d)
        seg_d[7*i +: 7] = SEG_DASH;
      else if (blank_q && i > msd)
        seg_d[7*i +: 7] = (neg_q && i == msd + 1) ? SEG_DASH : SEG_BLANK;
      else if (!blank_q && neg_q && i == NUM_DIGITS - 1)
        seg_d[7*i +: 7] = SEG_DASH;
      else
        seg_d[7*i +: 7] = glyph(buf_q[i]);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q   <= S_LATCH;
      hex_out_q <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= 1'b1;
      done_q  <= (state_q == S_COMMIT);
      if (state_q == S_COMMIT) begin
        hex_out_q <= seg_d;
        ovf_q     <= ovf_d;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    case (state_q)
      S_LATCH: begin
        work_q  <= in_mag;
        neg_q   <= in_neg;
        hex_q   <= bus.hex_mode;
        blank_q <= bus.blank_leading;
        digit_q <= '0;
      end
      S_STORE: begin
        buf_q[digit_q] <= hex_q ? work_q[3:0] : div_rem;
        work_q         <= hex_q ? (work_q >> 4) : div_quo;
        digit_q        <= digit_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.HEX         = hex_out_q;
  assign bus.busy        = busy_q;
  assign bus.update_done = done_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_multidigit_display.sv
// Scoreboard bench: each issued frame pushes its expected segments, a
// monitor pops and compares on every update_done pulse.
module tb_multidigit_display;
  localparam int N = 4;
  localparam int W = 32;
  localparam int LAT_DEC = 2 + N * (W + 1);
  localparam int LAT_HEX = 2 + N;

  typedef struct {
    logic [7*N-1:0] seg;
    logic           ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  multidigit_display_if #(.NUM_DIGITS(N), .WIDTH(W)) bus ();

  multidigit_display #(.NUM_DIGITS(N), .WIDTH(W)) dut (
    .CLOCK_50(clk),
    .RST     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0": return 7'h40;  "1": return 7'h79;  "2": return 7'h24;  "3": return 7'h30;
      "4": return 7'h19;  "5": return 7'h12;  "6": return 7'h02;  "7": return 7'h78;
      "8": return 7'h00;  "9": return 7'h10;  "a": return 7'h08;  "b": return 7'h03;
      "c": return 7'h46;  "d": return 7'h21;  "e": return 7'h06;  "f": return 7'h0E;
      "-": return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference: render the value as text, then map characters to glyphs.
  function automatic exp_t model(input logic [31:0] v, input bit hx, input bit sg, input bit bl);
    exp_t   e;
    bit     neg;
    longint mag;
    string  digs, txt;
    neg  = sg && !hx && v[31];
    mag  = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    digs = hx ? $sformatf("%0h", mag) : $sformatf("%0d", mag);
    e.ovf = (digs.len() + (neg ? 1 : 0)) > N;
    txt = "";
    if (e.ovf) begin
      for (int i = 0; i < N; i++) txt = {txt, "-"};
    end else if (bl) begin
      txt = neg ? {"-", digs} : digs;
      while (txt.len() < N) txt = {" ", txt};
    end else begin
      txt = digs;
      while (txt.len() < N - (neg ? 1 : 0)) txt = {"0", txt};
      if (neg) txt = {"-", txt};
    end
    for (int i = 0; i < N; i++) e.seg[7*i +: 7] = seg_of(txt[N-1-i]);
    return e;
  endfunction

  task automatic issue(input logic [31:0] v, input bit hx, input bit sg, input bit bl);
    bus.number_to_show = v;
    bus.hex_mode       = hx;
    bus.signed_mode    = sg;
    bus.blank_leading  = bl;
    sb.push_back(model(v, hx, sg, bl));
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.update_done && cycles < 400);
    if (!bus.update_done) check("update_timeout", 64'd0, 64'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.update_done) begin
        if (sb.size() == 0) begin
          check("unexpected_update", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("hex", 64'(bus.HEX), 64'(e.seg));
          check("overflow", 64'(bus.overflow), 64'(e.ovf));
        end
      end
    end
  end

  initial begin : stimulus
    int cyc;
    int kind;
    bit hx, sg, bl;
    logic [31:0] v;

    bus.number_to_show = '0;
    bus.hex_mode       = 1'b0;
    bus.signed_mode    = 1'b0;
    bus.blank_leading  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hex", 64'(bus.HEX), 64'(28'hFFFFFFF));
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_update_done", 64'(bus.update_done), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);

    issue(32'd1234, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("busy_running", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    check("first_latency", 64'(cyc + 1), 64'(LAT_DEC));
    check("digit0_4", 64'(bus.HEX[6:0]), 64'h19);

    issue(32'd42, 0, 0, 1);          wait_done(cyc);
    check("dec_latency", 64'(cyc), 64'(LAT_DEC));
    issue(32'd0, 0, 0, 1);           wait_done(cyc);
    issue(32'hFFFF_FFD6, 0, 1, 1);   wait_done(cyc);
    issue(32'hFFFF_FFD6, 0, 1, 0);   wait_done(cyc);
    issue(32'hFFFF_FC18, 0, 1, 0);   wait_done(cyc);
    issue(32'd10000, 0, 0, 0);       wait_done(cyc);
    issue(32'd9999, 0, 0, 0);        wait_done(cyc);
    issue(32'h0000_BEEF, 1, 0, 0);   wait_done(cyc);
    issue(32'h0000_BEEF, 1, 0, 1);   wait_done(cyc);
    check("hex_period", 64'(cyc), 64'(LAT_HEX));
    issue(32'h0001_0000, 1, 0, 0);   wait_done(cyc);
    issue(32'hFFFF_FFFF, 1, 1, 0);   wait_done(cyc);

    // Input change in the middle of a decimal conversion.
    issue(32'd5678, 0, 0, 0);
    repeat (50) @(negedge clk);
    bus.number_to_show = 32'd8765;
    wait_done(cyc);
    issue(32'd8765, 0, 0, 0);        wait_done(cyc);

    // Reset in the middle of a conversion.
    issue(32'd4321, 0, 0, 1);
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hex", 64'(bus.HEX), 64'(28'hFFFFFFF));
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_overflow", 64'(bus.overflow), 64'd0);
    sb.delete();
    issue(32'd4321, 0, 0, 1);
    rst = 1'b0;
    wait_done(cyc);
    check("restart_latency", 64'(cyc), 64'(LAT_DEC));

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      bl   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      case (kind)
        0: begin v = $urandom_range(0, 9999); hx = 0; sg = 0; end
        1: begin v = $urandom;                hx = 0; end
        2: begin v = 32'd0 - 32'($urandom_range(0, 999)); hx = 0; sg = 1; end
        3: begin v = $urandom_range(0, 16'hFFFF); hx = 1; end
        default: begin v = $urandom; hx = 1; end
      endcase
      issue(v, hx, sg, bl);
      wait_done(cyc);
      check("rand_latency", 64'(cyc), 64'(hx ? LAT_HEX : LAT_DEC));
    end

    @(posedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
